muldiv_ctrl: RTL and testbench
==============================

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have parameter MUL_LAT, default 5: busy cycles after a multiply issue; legal range 1..15.
REQ-002 SHALL have parameter DIV_LAT, default 10: busy cycles after a divide issue; legal range 1..15.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  E-stage holds mult/multu/div/divu.
REQ-006 SHALL have port req_op  input  2  00 multu, 01 mult, 10 divu, 11 div.
REQ-007 SHALL have port mt_valid  input  1  E-stage holds mthi/mtlo.
REQ-008 SHALL have port mt_sel  input  1  0 = LO, 1 = HI.
REQ-009 SHALL have port d_uses_md  input  1  D-stage holds mult/div/mthi/mtlo/mfhi/mflo.
REQ-010 SHALL have port flush  input  1  E-stage instruction killed this cycle.
REQ-011 SHALL have port start  output  1  one-cycle issue strobe to the mul/div unit.
REQ-012 SHALL have port md_op  output  3  operation code to the unit; 3'b1xx = no-op.
REQ-013 SHALL have port mthilo  output  2  00 write LO, 01 write HI, 11 none.
REQ-014 SHALL have port busy  output  1  unit occupied.
REQ-015 SHALL have port stall  output  1  freeze F/D and bubble E.
REQ-016 SHALL have port cycles_left  output  4  remaining busy cycles.
REQ-017 SHALL have port overrun  output  1  sticky: request or move presented while busy.

Function
REQ-018 SHALL implement states IDLE, MUL, DIV in a registered state register.
REQ-019 SHALL assert start combinationally when state==IDLE, req_valid=1 and flush=0.
REQ-020 SHALL drive md_op = {1'b0, req_op} while start=1, else 3'b100.
REQ-021 SHALL, at the edge where start=1, enter MUL (req_op[1]=0) or DIV (req_op[1]=1) and load cycles_left with MUL_LAT or DIV_LAT respectively.
REQ-022 SHALL, in MUL/DIV, decrement cycles_left each edge; the edge at which cycles_left==1 returns state to IDLE with cycles_left=0.
REQ-023 SHALL drive busy = (state!=IDLE); busy is therefore high for exactly MUL_LAT or DIV_LAT cycles after the issue edge.
REQ-024 SHALL drive mthilo = {1'b0, mt_sel} when state==IDLE, mt_valid=1, flush=0, and req_valid=0; otherwise 2'b11.
REQ-025 SHALL, when req_valid and mt_valid are both high, give the request priority, suppress the move, and set overrun.
REQ-026 SHALL drive stall = d_uses_md & (busy | start), combinationally.
REQ-027 SHALL ignore req_valid/mt_valid while busy: no start, mthilo=11, state/counter unaffected; set overrun at that edge.
REQ-028 SHALL not abort an in-flight operation on flush; flush only suppresses same-cycle start/mthilo.
REQ-029 SHALL hold overrun high until reset once set.
REQ-030 SHALL make start, md_op, mthilo, stall pure functions of current state and inputs (no added latency).

Reset
REQ-031 SHALL on reset=0, immediately and independent of clk, force state=IDLE, cycles_left=0, busy=0, overrun=0.
REQ-032 SHALL hold start=0, mthilo=11, md_op=3'b100 while reset=0, regardless of inputs.
REQ-033 SHALL, on reset asserted mid-operation, discard the operation; after release the block is IDLE and accepts a request on the first clock edge.

Verification
REQ-034 SHALL be verified by: mult (req_op=01) in IDLE -> start=1, md_op=001 same cycle; busy high 5 cycles, cycles_left 5,4,3,2,1, then 0/IDLE.
REQ-035 SHALL be verified by: div (req_op=11) then d_uses_md=1 held -> stall=1 on issue cycle plus 10 busy cycles, stall=0 on the 11th cycle after the issue edge.
REQ-036 SHALL be verified by: req_valid=1 with flush=1 in IDLE -> start=0, state stays IDLE, busy=0.
REQ-037 SHALL be verified by: mt_valid=1, mt_sel=1 in IDLE -> mthilo=01; same during MUL -> mthilo=11, overrun=1 sticky.
REQ-038 SHALL be verified by: reset pulled low at cycles_left=4 of a divide, between clock edges -> busy=0, cycles_left=0 immediately; mult after release starts normally.
REQ-039 SHALL be verified by: req_valid and mt_valid both high in IDLE -> start=1, mthilo=11, overrun=1.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// Issue/stall/occupancy controller for a multi-cycle multiply/divide unit.
// Tracks unit occupancy with a latency down-counter and flags collisions.
//
// state | meaning
// IDLE  | unit free, requests and HI/LO moves accepted
// MUL   | multiply in flight, counter running down from MUL_LAT
// DIV   | divide in flight, counter running down from DIV_LAT
module muldiv_ctrl #(
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned DIV_LAT = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [1:0] req_op,
    input  logic       mt_valid,
    input  logic       mt_sel,
    input  logic       d_uses_md,
    input  logic       flush,
    output logic       start,
    output logic [2:0] md_op,
    output logic [1:0] mthilo,
    output logic       busy,
    output logic       stall,
    output logic [3:0] cycles_left,
    output logic       overrun
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    localparam logic [3:0] MUL_CNT = 4'(MUL_LAT);
    localparam logic [3:0] DIV_CNT = 4'(DIV_LAT);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       ovr_q, ovr_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovr_q   <= ovr_d;
        end
    end

    // Strobes are gated by reset so nothing leaks out while it is held low.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovr_d   = ovr_q;
        start   = 1'b0;
        md_op   = 3'b100;
        mthilo  = 2'b11;
        if (reset) begin
            case (state_q)
                IDLE: begin
                    if (req_valid && !flush) begin
                        start   = 1'b1;
                        md_op   = {1'b0, req_op};
                        state_d = req_op[1] ? DIV : MUL;
                        cnt_d   = req_op[1] ? DIV_CNT : MUL_CNT;
                    end else if (mt_valid && !flush && !req_valid) begin
                        mthilo = {1'b0, mt_sel};
                    end
                    if (req_valid && mt_valid) begin
                        ovr_d = 1'b1;
                    end
                end
                MUL, DIV: begin
                    if (cnt_q == 4'd1) begin
                        state_d = IDLE;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                    if (req_valid || mt_valid) begin
                        ovr_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    assign busy        = (state_q != IDLE);
    assign stall       = d_uses_md & (busy | start);
    assign cycles_left = cnt_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: stimulus pushes hand-computed expectations,
// a monitor pops and compares them after each negative clock edge or reset drop.
module tb_muldiv_ctrl;

    localparam logic [2:0] NOP = 3'b100;
    localparam logic [1:0] NM  = 2'b11;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid, mt_valid, mt_sel, d_uses_md, flush;
    logic [1:0] req_op;
    logic       start, busy, stall, overrun;
    logic [2:0] md_op;
    logic [1:0] mthilo;
    logic [3:0] cycles_left;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        string      name;
        logic       st;
        logic [2:0] md;
        logic [1:0] mth;
        logic       bsy;
        logic       stl;
        logic [3:0] cl;
        logic       ovr;
    } exp_t;

    exp_t sb_q[$];

    muldiv_ctrl #(.MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .mt_valid   (mt_valid),
        .mt_sel     (mt_sel),
        .d_uses_md  (d_uses_md),
        .flush      (flush),
        .start      (start),
        .md_op      (md_op),
        .mthilo     (mthilo),
        .busy       (busy),
        .stall      (stall),
        .cycles_left(cycles_left),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic push(input string nm, input logic e_st, input logic [2:0] e_md,
                        input logic [1:0] e_mth, input logic e_busy, input logic e_stall,
                        input logic [3:0] e_cl, input logic e_ovr);
        exp_t e;
        e.name = nm;
        e.st   = e_st;
        e.md   = e_md;
        e.mth  = e_mth;
        e.bsy  = e_busy;
        e.stl  = e_stall;
        e.cl   = e_cl;
        e.ovr  = e_ovr;
        sb_q.push_back(e);
    endtask

    task automatic step(input string nm, input logic r, input logic rv, input logic [1:0] op,
                        input logic mv, input logic ms, input logic du, input logic fl,
                        input logic e_st, input logic [2:0] e_md, input logic [1:0] e_mth,
                        input logic e_busy, input logic e_stall, input logic [3:0] e_cl,
                        input logic e_ovr);
        @(posedge clk);
        #1;
        reset     = r;
        req_valid = rv;
        req_op    = op;
        mt_valid  = mv;
        mt_sel    = ms;
        d_uses_md = du;
        flush     = fl;
        push(nm, e_st, e_md, e_mth, e_busy, e_stall, e_cl, e_ovr);
    endtask

    task automatic idle_cyc(input string nm, input logic e_busy, input logic [3:0] e_cl,
                            input logic e_ovr);
        step(nm, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0,
             1'b0, NOP, NM, e_busy, 1'b0, e_cl, e_ovr);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or negedge reset);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_checks++;
                if ({start, md_op, mthilo, busy, stall, cycles_left, overrun} !==
                    {e.st, e.md, e.mth, e.bsy, e.stl, e.cl, e.ovr}) begin
                    $display("FAIL %s: got start=%b md_op=%b mthilo=%b busy=%b stall=%b cl=%0d ovr=%b, want start=%b md_op=%b mthilo=%b busy=%b stall=%b cl=%0d ovr=%b",
                             e.name, start, md_op, mthilo, busy, stall, cycles_left, overrun,
                             e.st, e.md, e.mth, e.bsy, e.stl, e.cl, e.ovr);
                end else begin
                    n_pass++;
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, got %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

    // Stimulus
    initial begin
        reset = 1'b0; req_valid = 1'b0; req_op = 2'b00; mt_valid = 1'b0;
        mt_sel = 1'b0; d_uses_md = 1'b0; flush = 1'b0;

        step("reset_hold", 1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0,
             1'b0, NOP, NM, 1'b0, 1'b0, 4'd0, 1'b0);
        idle_cyc("idle_after_rst", 1'b0, 4'd0, 1'b0);

        step("mul_issue", 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0,
             1'b1, 3'b001, NM, 1'b0, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 5; i++) idle_cyc("mul_busy", 1'b1, 4'(5 - i), 1'b0);
        idle_cyc("mul_done", 1'b0, 4'd0, 1'b0);

        step("flush_req", 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1,
             1'b0, NOP, NM, 1'b0, 1'b0, 4'd0, 1'b0);
        idle_cyc("flush_idle", 1'b0, 4'd0, 1'b0);

        step("mthi_idle", 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0,
             1'b0, NOP, 2'b01, 1'b0, 1'b0, 4'd0, 1'b0);
        step("mtlo_idle", 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0,
             1'b0, NOP, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0);

        step("div_issue", 1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0,
             1'b1, 3'b011, NM, 1'b0, 1'b1, 4'd0, 1'b0);
        for (int i = 0; i < 10; i++)
            step("div_stall", 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0,
                 1'b0, NOP, NM, 1'b1, 1'b1, 4'(10 - i), 1'b0);
        step("div_unstall", 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0,
             1'b0, NOP, NM, 1'b0, 1'b0, 4'd0, 1'b0);

        step("multu_issue", 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0,
             1'b1, 3'b000, NM, 1'b0, 1'b0, 4'd0, 1'b0);
        step("mt_busy", 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0,
             1'b0, NOP, NM, 1'b1, 1'b0, 4'd5, 1'b0);
        idle_cyc("ovr_set", 1'b1, 4'd4, 1'b1);
        step("req_busy", 1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0,
             1'b0, NOP, NM, 1'b1, 1'b0, 4'd3, 1'b1);
        idle_cyc("no_reload", 1'b1, 4'd2, 1'b1);
        idle_cyc("no_reload", 1'b1, 4'd1, 1'b1);
        idle_cyc("ovr_sticky", 1'b0, 4'd0, 1'b1);

        step("rst_clr_ovr", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0,
             1'b0, NOP, NM, 1'b0, 1'b0, 4'd0, 1'b0);
        idle_cyc("rst_release", 1'b0, 4'd0, 1'b0);

        step("both_req_mt", 1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0,
             1'b1, 3'b000, NM, 1'b0, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 5; i++) idle_cyc("both_busy", 1'b1, 4'(5 - i), 1'b1);
        idle_cyc("both_done", 1'b0, 4'd0, 1'b1);

        step("divu_issue", 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0,
             1'b1, 3'b010, NM, 1'b0, 1'b0, 4'd0, 1'b1);
        for (int i = 0; i < 7; i++) idle_cyc("divu_busy", 1'b1, 4'(10 - i), 1'b1);

        // Drop reset between edges while cycles_left is 4.
        @(negedge clk);
        #2;
        reset = 1'b0;
        push("mid_reset", 1'b0, NOP, NM, 1'b0, 1'b0, 4'd0, 1'b0);

        step("rst_hold_req", 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0,
             1'b0, NOP, NM, 1'b0, 1'b0, 4'd0, 1'b0);
        step("mul_after_rst", 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0,
             1'b1, 3'b001, NM, 1'b0, 1'b0, 4'd0, 1'b0);
        idle_cyc("mul_after_busy", 1'b1, 4'd5, 1'b0);
        idle_cyc("mul_after_busy", 1'b1, 4'd4, 1'b0);

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        #2;
        if (sb_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
